// File: rtl/insn_monitor_if.sv
// Instruction monitor bus: controller status in, display drive out.
// master = controller side, slave = monitor side.
interface insn_monitor_if;
    logic [3:0]  state;
    logic [3:0]  insn_type;
    logic [3:0]  insn_code;
    logic [2:0]  insn_stage;
    logic        mode_btn;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] insn_cnt;

    modport master (
        output state,
        output insn_type,
        output insn_code,
        output insn_stage,
        output mode_btn,
        input  seg,
        input  an,
        input  insn_cnt
    );

    modport slave (
        input  state,
        input  insn_type,
        input  insn_code,
        input  insn_stage,
        input  mode_btn,
        output seg,
        output an,
        output insn_cnt
    );
endinterface

// File: rtl/insn_monitor.sv
// Four-digit hex monitor of controller state and retired-insn count.
// Optional CYCLE_COUNT_EN adds a cycle counter shown as page 2.
module insn_monitor #(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic         clk,
    input  logic         rst,
    insn_monitor_if.slave bus
);

`ifdef CYCLE_COUNT_EN
    localparam logic [1:0] LAST_PAGE = 2'd2;
`else
    localparam logic [1:0] LAST_PAGE = 2'd1;
`endif

    logic [15:0] scan_cnt;
    logic [1:0]  idx;
    logic        btn_s1;
    logic        btn_s2;
    logic        btn_s3;
    logic        btn_rise;
    logic [1:0]  page;
    logic [2:0]  prev_stage;
    logic        retire;
    logic [15:0] cnt;
    logic [15:0] page_word;
    logic [3:0]  nibble;
    logic [7:0]  seg_dec;
    logic [7:0]  seg_q;
    logic [3:0]  an_q;
`ifdef CYCLE_COUNT_EN
    logic [15:0] cyc_cnt;
`endif

    assign btn_rise = btn_s2 & ~btn_s3;
    assign retire   = (bus.insn_stage == 3'b000) &&
                      (prev_stage != 3'b000);

    // Scan divider and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= 16'd0;
            idx      <= 2'd0;
        end else if (scan_cnt == SCAN_DIV - 16'd1) begin
            scan_cnt <= 16'd0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    // Button synchronizer plus one flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            btn_s3 <= 1'b0;
        end else begin
            btn_s1 <= bus.mode_btn;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
        end
    end

    // Page select, advanced on each synchronized press.
    always_ff @(posedge clk) begin
        if (rst) begin
            page <= 2'd0;
        end else if (btn_rise) begin
            page <= (page == LAST_PAGE) ? 2'd0 : page + 2'd1;
        end
    end

    // Retire counter: count entry into IF, not time spent in it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_stage <= 3'b000;
            cnt        <= 16'd0;
        end else begin
            prev_stage <= bus.insn_stage;
            if (retire) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

`ifdef CYCLE_COUNT_EN
    // Free-running cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= 16'd0;
        end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
        end
    end
`endif

    // Select the 16-bit word for the current page.
    always_comb begin
        page_word = {bus.insn_type, bus.insn_code,
                     1'b0, bus.insn_stage, bus.state};
        case (page)
            2'd1:    page_word = cnt;
`ifdef CYCLE_COUNT_EN
            2'd2:    page_word = cyc_cnt;
`endif
            default: ;
        endcase
    end

    assign nibble = page_word[{idx, 2'b00} +: 4];

    // Common-anode hex decode, dp held off.
    always_comb begin
        seg_dec = 8'hFF;
        case (nibble)
            4'h0: seg_dec = 8'hC0;
            4'h1: seg_dec = 8'hF9;
            4'h2: seg_dec = 8'hA4;
            4'h3: seg_dec = 8'hB0;
            4'h4: seg_dec = 8'h99;
            4'h5: seg_dec = 8'h92;
            4'h6: seg_dec = 8'h82;
            4'h7: seg_dec = 8'hF8;
            4'h8: seg_dec = 8'h80;
            4'h9: seg_dec = 8'h90;
            4'hA: seg_dec = 8'h88;
            4'hB: seg_dec = 8'h83;
            4'hC: seg_dec = 8'hC6;
            4'hD: seg_dec = 8'hA1;
            4'hE: seg_dec = 8'h86;
            4'hF: seg_dec = 8'h8E;
            default: seg_dec = 8'hFF;
        endcase
    end

    // Registered digit drive, one cycle behind idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= 8'hFF;
            an_q  <= 4'hF;
        end else begin
            seg_q <= seg_dec;
            an_q  <= ~(4'b0001 << idx);
        end
    end

    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
    assign bus.insn_cnt = cnt;

endmodule

// File: tb/tb_insn_monitor.sv
// Scoreboard bench for insn_monitor with SCAN_DIV = 4.
// Optional CYCLE_COUNT_EN must match the RTL build.
module tb_insn_monitor;

    localparam int SD = 4;

`ifdef CYCLE_COUNT_EN
    localparam int NPAGES = 3;
`else
    localparam int NPAGES = 2;
`endif

    typedef struct {
        logic [7:0]  seg;
        logic [3:0]  an;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    insn_monitor_if bus();

    insn_monitor #(.SCAN_DIV(16'(SD))) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    bit sb_on    = 1'b1;
    exp_t sb_q[$];

    int          m_scan = 0;
    logic [1:0]  m_idx  = 2'd0;
    int          m_page = 0;
    logic        m_s1 = 1'b0;
    logic        m_s2 = 1'b0;
    logic        m_s3 = 1'b0;
    logic [2:0]  m_prev = 3'b000;
    logic [15:0] m_cnt = 16'd0;
    logic [15:0] m_cyc = 16'd0;

    task automatic check(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [3:0] pick(input int pg,
                                        input int d);
        logic [15:0] w;
        case (pg)
            1:       w = m_cnt;
            2:       w = m_cyc;
            default: w = {bus.insn_type, bus.insn_code,
                          1'b0, bus.insn_stage, bus.state};
        endcase
        w = w >> (4 * d);
        return w[3:0];
    endfunction

    task automatic tick();
        exp_t e;
        exp_t g;
        logic retire;
        logic rise;
        if (rst) begin
            e.seg  = 8'hFF;
            e.an   = 4'hF;
            m_scan = 0;
            m_idx  = 2'd0;
            m_page = 0;
            m_s1   = 1'b0;
            m_s2   = 1'b0;
            m_s3   = 1'b0;
            m_prev = 3'b000;
            m_cnt  = 16'd0;
            m_cyc  = 16'd0;
        end else begin
            e.seg = hex7(pick(m_page, int'(m_idx)));
            e.an  = 4'hF;
            e.an[m_idx] = 1'b0;
            retire = (bus.insn_stage == 3'b000) &&
                     (m_prev != 3'b000);
            rise = m_s2 && !m_s3;
            if (m_scan == SD - 1) begin
                m_scan = 0;
                m_idx  = m_idx + 2'd1;
            end else begin
                m_scan++;
            end
            m_s3 = m_s2;
            m_s2 = m_s1;
            m_s1 = bus.mode_btn;
            if (rise) m_page = (m_page + 1) % NPAGES;
            if (retire) m_cnt = m_cnt + 16'd1;
            m_prev = bus.insn_stage;
            m_cyc  = m_cyc + 16'd1;
        end
        e.cnt = m_cnt;
        if (sb_on) sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_on && sb_q.size() > 0) begin
            g = sb_q.pop_front();
            check("sb_seg", 16'(bus.seg), 16'(g.seg));
            check("sb_an",  16'(bus.an),  16'(g.an));
            check("sb_cnt", bus.insn_cnt, g.cnt);
        end
    endtask

    task automatic do_reset(input logic [2:0] stg);
        rst = 1'b1;
        bus.insn_stage = stg;
        tick();
        rst = 1'b0;
    endtask

    task automatic retires(input int n);
        for (int i = 0; i < n; i++) begin
            bus.insn_stage = 3'b001;
            tick();
            bus.insn_stage = 3'b000;
            tick();
        end
        bus.insn_stage = 3'b001;
    endtask

    logic [7:0] scan_seg[4];
    logic [3:0] scan_an[4];
    logic [2:0] seq[7];

    initial begin
        scan_seg = '{8'hA4, 8'hA4, 8'hB0, 8'hF9};
        scan_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seq = '{3'b000, 3'b001, 3'b010, 3'b100,
                3'b000, 3'b001, 3'b000};

        rst = 1'b1;
        bus.state      = 4'h2;
        bus.insn_type  = 4'h1;
        bus.insn_code  = 4'h3;
        bus.insn_stage = 3'b010;
        bus.mode_btn   = 1'b0;
        tick();
        tick();
        check("rst_seg", 16'(bus.seg), 16'h00FF);
        check("rst_an",  16'(bus.an),  16'h000F);
        check("rst_cnt", bus.insn_cnt, 16'h0000);

        rst = 1'b0;
        for (int e = 0; e < 16; e++) begin
            tick();
            check("scan_an",  16'(bus.an),  16'(scan_an[e / 4]));
            check("scan_seg", 16'(bus.seg), 16'(scan_seg[e / 4]));
        end

        do_reset(3'b000);
        for (int i = 0; i < 7; i++) begin
            bus.insn_stage = seq[i];
            tick();
            if (i == 0) check("if_at_release", bus.insn_cnt, 16'd0);
        end
        check("retire_seq", bus.insn_cnt, 16'd2);
        bus.insn_stage = 3'b000;
        for (int i = 0; i < 10; i++) tick();
        check("retire_hold", bus.insn_cnt, 16'd2);

        do_reset(3'b001);
        retires(165);
        tick();
        check("cnt_a5", bus.insn_cnt, 16'h00A5);
        bus.mode_btn = 1'b1;
        tick();
        tick();
        tick();
        bus.mode_btn = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            case (bus.an)
                4'b1110: check("pg1_d0", 16'(bus.seg), 16'h0092);
                4'b1101: check("pg1_d1", 16'(bus.seg), 16'h0088);
                4'b1011: check("pg1_d2", 16'(bus.seg), 16'h00C0);
                4'b0111: check("pg1_d3", 16'(bus.seg), 16'h00C0);
                default: check("pg1_an", 16'(bus.an),  16'h000E);
            endcase
        end

        bus.mode_btn = 1'b1;
        tick();
        tick();
        bus.insn_stage = 3'b000;
        tick();
        bus.mode_btn   = 1'b0;
        bus.insn_stage = 3'b001;
        tick();
        check("retire_and_page", bus.insn_cnt, 16'h00A6);
        for (int i = 0; i < 16; i++) tick();
`ifdef CYCLE_COUNT_EN
        bus.mode_btn = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.mode_btn = 1'b0;
        tick();
`endif
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.an == 4'b1110)
                check("page_wrap", 16'(bus.seg), 16'h00A4);
        end

        do_reset(3'b001);
        retires(16);
        for (int i = 0; i < 5; i++) tick();
        check("cnt_10", bus.insn_cnt, 16'h0010);
        rst = 1'b1;
        tick();
        check("midrst_seg", 16'(bus.seg), 16'h00FF);
        check("midrst_an",  16'(bus.an),  16'h000F);
        check("midrst_cnt", bus.insn_cnt, 16'h0000);
        rst = 1'b0;
        tick();
        check("post_rst_an", 16'(bus.an), 16'h000E);

        do_reset(3'b001);
        sb_on = 1'b0;
        retires(65535);
        tick();
        check("cnt_ffff", bus.insn_cnt, 16'hFFFF);
        sb_on = 1'b1;
        retires(1);
        tick();
        check("cnt_wrap", bus.insn_cnt, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/insn_monitor.md
INSN_MONITOR -- requirements
Module: insn_monitor

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16'd50000, digit-scan period in clk cycles (legal range 2..65535).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 state  input  4  controller FSM state code.
REQ-005 insn_type  input  4  controller instruction-class code.
REQ-006 insn_code  input  4  controller instruction-mnemonic code.
REQ-007 insn_stage  input  3  controller stage code (3'b000 = IF).
REQ-008 mode_btn  input  1  asynchronous page-select button, active-high.
REQ-009 seg  output  8  segment drive, active-low, bit7 = dp, bits6..0 = g..a.
REQ-010 an  output  4  digit enables, active-low, bit0 = rightmost digit.
REQ-011 insn_cnt  output  16  retired-instruction count.

Function
REQ-012 Scan divider SHALL count 0..SCAN_DIV-1 and wrap; on each wrap, digit index SHALL advance 0->1->2->3->0.
REQ-013 Every cycle, an SHALL be registered to all-ones except bit[idx]=0, and seg SHALL be registered to the hex decode of nibble[idx]; one-cycle latency from idx change to outputs.
REQ-014 Decode SHALL be common-anode hex: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E; dp (seg[7]) always 1.
REQ-015 Page 0 nibbles (digit3..0): insn_type, insn_code, {1'b0,insn_stage}, state; inputs sampled live, no extra registering.
REQ-016 Page 1 nibbles: insn_cnt[15:12], [11:8], [7:4], [3:0].
REQ-017 mode_btn SHALL pass a 2-flop synchronizer; a rising edge of the synchronized signal SHALL advance page by one, wrapping after the last page.
REQ-018 Register prev_stage SHALL hold insn_stage from the previous cycle.
REQ-019 Retire event SHALL be insn_stage==3'b000 && prev_stage!=3'b000; insn_cnt SHALL increment by 1 on that cycle's edge, visible next cycle.
REQ-020 insn_cnt SHALL wrap 16'hFFFF -> 16'h0000 with no flag.
REQ-021 Retire and page advance on the same cycle SHALL both take effect.
REQ-022 Stage held at 3'b000 for multiple cycles SHALL count once.

Reset
REQ-023 On rst=1 at a clk edge: insn_cnt=0, scan divider=0, idx=0, page=0, synchronizer flops=0, prev_stage=3'b000, seg=8'hFF, an=4'hF.
REQ-024 Reset asserted mid-scan or mid-count SHALL take priority over all other updates in that cycle.
REQ-025 First cycle after reset release SHALL drive an=4'b1110 with digit-0 decode.
REQ-026 Because prev_stage resets to 3'b000, an IF stage present at reset release SHALL NOT count.

Configuration
REQ-027 Macro CYCLE_COUNT_EN: when defined, a 16-bit cycle counter SHALL increment every non-reset cycle, wrap at 16'hFFFF, reset to 0, and be shown as page 2 (hex, same layout as page 1); pages cycle 0->1->2->0.
REQ-028 Without CYCLE_COUNT_EN: no cycle counter logic; pages cycle 0->1->0.

Verification
REQ-029 SCAN_DIV=4, release rst, page 0, state=4'h2, insn_stage=3'b010, insn_code=4'h3, insn_type=4'h1 -> an steps 1110,1101,1011,0111 every 4 cycles; seg A4, A4, B0, F9 respectively.
REQ-030 Drive insn_stage 000,001,010,100,000,001,000 (one cycle each, after reset) -> insn_cnt=2; hold 000 for 10 cycles -> insn_cnt unchanged.
REQ-031 Force 65535 retire events -> insn_cnt=16'hFFFF; one more -> 16'h0000.
REQ-032 Pulse mode_btn high 3 cycles -> page advances exactly once, 3 cycles after rise; page 1 with insn_cnt=16'h00A5 shows digits 0,0,A,5 (C0,C0,88,92).
REQ-033 With CYCLE_COUNT_EN, three mode_btn pulses -> pages 1,2,0; page 2 shows cycle count; without it, two pulses return to page 0.
REQ-034 Assert rst for 1 cycle mid-scan with insn_cnt=16'h0010 -> next cycle seg=FF, an=F, insn_cnt=0; following cycle an=1110.
